// File: rtl/mux_scan_if.sv
// Handshake bundle between the mux scan controller and its requesters/consumer.
// The master side drives req/q_in/ack, and the slave (controller) side drives the select and sample outputs.
interface mux_scan_if;
    logic [3:0] req;
    logic       q_in;
    logic       ack;
    logic [1:0] select;
    logic [3:0] grant;
    logic       sample;
    logic [1:0] sample_ch;
    logic       sample_valid;

    modport master (
        output req, q_in, ack,
        input  select, grant, sample, sample_ch, sample_valid
    );

    modport slave (
        input  req, q_in, ack,
        output select, grant, sample, sample_ch, sample_valid
    );
endinterface

// File: rtl/mux_scan_controller.sv
// Round-robin scan of a 4:1 mux: pick a requesting channel, hold select DWELL cycles, capture q_in.
// Latency: grant one edge after req is seen, sample_valid DWELL edges later; sample holds until ack.
// Optional MUX_SCAN_BACK_TO_BACK_EN: re-arbitrate on the accepting edge, skipping the idle cycle.
module mux_scan_controller #(
    parameter int DWELL = 3
) (
    input  logic        clk,
    input  logic        reset,
    mux_scan_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_ACK} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [1:0] ptr, ptr_nx;
    logic [1:0] select_q, select_nx;
    logic [3:0] grant_q, grant_nx;
    logic       sample_q, sample_nx;
    logic [1:0] sample_ch_q, sample_ch_nx;
    logic       sample_valid_q, sample_valid_nx;

    // First requesting channel at or above p, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            ptr            <= 2'd0;
            select_q       <= 2'd0;
            grant_q        <= 4'd0;
            sample_q       <= 1'b0;
            sample_ch_q    <= 2'd0;
            sample_valid_q <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            ptr            <= ptr_nx;
            select_q       <= select_nx;
            grant_q        <= grant_nx;
            sample_q       <= sample_nx;
            sample_ch_q    <= sample_ch_nx;
            sample_valid_q <= sample_valid_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        ptr_nx          = ptr;
        select_nx       = select_q;
        grant_nx        = grant_q;
        sample_nx       = sample_q;
        sample_ch_nx    = sample_ch_q;
        sample_valid_nx = sample_valid_q;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    select_nx = pick(bus.req, ptr);
                    grant_nx  = 4'b0001 << pick(bus.req, ptr);
                    cnt_nx    = 4'(DWELL - 1);
                    state_nx  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    sample_nx       = bus.q_in;
                    sample_ch_nx    = select_q;
                    sample_valid_nx = 1'b1;
                    state_nx        = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ack && sample_valid_q) begin
                    sample_valid_nx = 1'b0;
                    grant_nx        = 4'd0;
                    ptr_nx          = select_q + 2'd1;
                    state_nx        = IDLE;
`ifdef MUX_SCAN_BACK_TO_BACK_EN
                    // Arbitrate from the advanced pointer so the next grant lands on this same edge.
                    if (|bus.req) begin
                        select_nx = pick(bus.req, select_q + 2'd1);
                        grant_nx  = 4'b0001 << pick(bus.req, select_q + 2'd1);
                        cnt_nx    = 4'(DWELL - 1);
                        state_nx  = SETTLE;
                    end
`else
                    // Always pass through IDLE: at least one idle cycle between grants.
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.select       = select_q;
    assign bus.grant        = grant_q;
    assign bus.sample       = sample_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_valid = sample_valid_q;
endmodule

// File: doc/mux_scan_controller.md
MUX_SCAN_CONTROLLER -- requirements
Module: mux_scan_controller

Interface
REQ-001 The block SHALL have parameter DWELL, default 3, giving the number of cycles select is held before the mux output is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-channel sample request, bit i = mux data channel i.
REQ-005 q_in  input  1  output of the downstream 4:1 mux.
REQ-006 ack  input  1  consumer accepts the current sample.
REQ-007 select  output  2  drives the 4:1 mux select.
REQ-008 grant  output  4  one-hot channel currently being served; 0000 when none.
REQ-009 sample  output  1  captured value of q_in.
REQ-010 sample_ch  output  2  channel index that sample belongs to.
REQ-011 sample_valid  output  1  sample/sample_ch valid; holds until accepted.

Function
REQ-012 The block SHALL be a registered FSM with states IDLE, SETTLE, WAIT_ACK; all outputs SHALL be registers.
REQ-013 IDLE: if req != 0 at an edge, the block SHALL select the first set req bit searching upward from pointer ptr (modulo 4), load select/grant, load dwell counter with DWELL-1, and enter SETTLE on that edge.
REQ-014 IDLE with req == 0: state, select, grant SHALL hold; select keeps its last value.
REQ-015 SETTLE: at each edge, if counter != 0 it SHALL decrement; if counter == 0, sample <= q_in, sample_ch <= select, sample_valid <= 1, enter WAIT_ACK.
REQ-016 Latency: req recognized at edge N -> grant/select valid after edge N, sample_valid high after edge N+DWELL.
REQ-017 Once granted, a channel SHALL be served to completion even if its req bit drops during SETTLE or WAIT_ACK.
REQ-018 WAIT_ACK: sample, sample_ch, select, grant SHALL hold; req changes SHALL be ignored.
REQ-019 ack with sample_valid high at an edge: sample_valid <= 0, grant <= 0000, ptr <= select+1 (2-bit wrap, 3 -> 0), next state per REQ-027.
REQ-020 ack while sample_valid is low SHALL be ignored.
REQ-021 ptr SHALL only update on accepted samples; priority is strict round-robin, no channel starved while it keeps req high.
REQ-022 grant SHALL always be one-hot or zero and equal to (1 << select) whenever nonzero.

Reset
REQ-023 reset high at an edge SHALL force state IDLE, select 00, grant 0000, sample 0, sample_ch 00, sample_valid 0, counter 0, ptr 00, regardless of current state.
REQ-024 Reset asserted mid-SETTLE or mid-WAIT_ACK SHALL discard the pending sample; no sample_valid pulse follows.
REQ-025 Reset SHALL take priority over ack and req in the same cycle.

Configuration
REQ-026 Macro MUX_SCAN_BACK_TO_BACK_EN SHALL control back-to-back arbitration.
REQ-027 Defined: on an accepted ack with req != 0 (ptr taken as the updated value select+1), the block SHALL arbitrate in the same edge and enter SETTLE directly (zero idle cycles); with req == 0 it enters IDLE. Undefined: an accepted ack SHALL always enter IDLE (one idle cycle minimum before the next grant).

Verification (DWELL=3 unless stated)
REQ-028 Reset, then req=0001, q_in=1 -> grant=0001, select=00 one edge later; sample_valid=1, sample=1, sample_ch=00 three edges after grant; ack -> sample_valid=0, grant=0000.
REQ-029 req=1111 constant, ack high -> grant sequence 0001, 0010, 0100, 1000, 0001 (select 0,1,2,3,0).
REQ-030 req=1010 from reset -> served channels 1, 3, 1, 3.
REQ-031 ack low for 10 cycles in WAIT_ACK with req toggling -> sample_valid, sample, select, grant stable throughout; ack with sample_valid low at idle -> no state change.
REQ-032 reset pulsed one cycle during SETTLE (counter=1) -> all outputs zero next edge, no sample_valid, next grant starts from channel 0.
REQ-033 req=0011 with ack high: MUX_SCAN_BACK_TO_BACK_EN defined -> grant 0010 on the same edge sample_valid clears; undefined -> grant 0000 for exactly one cycle between grants.
